// File: rtl/sample_buffer_writer.sv
// sample_buffer_writer: write side of the ping-pong sample buffer.
// Decimates ADC samples and arms on a rising-edge level trigger, with an
// auto-trigger timeout. It then writes one DEPTH-sample frame into the bank
// that the drawer is not reading, and re-arms when the drawer swaps banks.
module sample_buffer_writer #(
   parameter int unsigned SAMPLE_WIDTH  = 12,
   parameter int unsigned ADD_SIZE      = 11,
   parameter int unsigned DEPTH         = 1280,
   parameter int unsigned DECIM_WIDTH   = 8,
   parameter int          TRIG_LEVEL    = 0,
   parameter int unsigned TIMEOUT_WIDTH = 12,
   parameter int unsigned TRIG_TIMEOUT  = 4095
) (
   input  logic                    CLK104MHZ,
   input  logic                    reset,
   input  logic [SAMPLE_WIDTH-1:0] sample_in,
   input  logic                    sample_valid,
   input  logic [DECIM_WIDTH-1:0]  decim,
   input  logic                    trig_en,
   input  logic                    activeBRAMselect,
   output logic [ADD_SIZE-1:0]     ADD_W,
   output logic [SAMPLE_WIDTH-1:0] DIN,
   output logic                    WE0,
   output logic                    WE1,
   output logic                    frame_ready,
   output logic                    auto_trig,
   output logic [7:0]              torn_count
);

   localparam logic [ADD_SIZE-1:0] LAST_ADDR = ADD_SIZE'(DEPTH - 1);
   localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TRIG_TIMEOUT - 1);
   localparam logic signed [SAMPLE_WIDTH-1:0] LEVEL = SAMPLE_WIDTH'(TRIG_LEVEL);

   typedef enum logic [1:0] {
      S_ARM  = 2'd0,
      S_FILL = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_n;

   logic                           sel_q;
   logic [DECIM_WIDTH-1:0]         dcnt;
   logic [TIMEOUT_WIDTH-1:0]       tcnt, tcnt_n;
   logic signed [SAMPLE_WIDTH-1:0] prev, prev_n;
   logic                           prev_valid, prev_valid_n;

   logic [ADD_SIZE-1:0]     add_w_n;
   logic [SAMPLE_WIDTH-1:0] din_n;
   logic                    we0_n, we1_n;
   logic                    frame_ready_n;
   logic                    auto_trig_n;
   logic [7:0]              torn_count_n;

   logic                           swap_c;
   logic                           accept_c;
   logic                           write_c;
   logic                           start_c;
   logic                           rise_c;
   logic signed [SAMPLE_WIDTH-1:0] cur_c;
   logic [ADD_SIZE-1:0]            addr_inc_c;

   // Swap and accept qualification; a swap discards a coincident sample
   always_comb begin
      swap_c     = (activeBRAMselect != sel_q);
      accept_c   = sample_valid && (dcnt == decim) && !swap_c;
      cur_c      = sample_in;
      rise_c     = prev_valid && (prev < LEVEL) && (cur_c >= LEVEL);
      addr_inc_c = (ADD_W == LAST_ADDR) ? ADD_W : ADD_W + ADD_SIZE'(1);
   end

   // Decimation counter and bank-select tracking
   always_ff @(posedge CLK104MHZ) begin
      if (reset) begin
         sel_q <= activeBRAMselect;
         dcnt  <= '0;
      end else begin
         sel_q <= activeBRAMselect;
         if (swap_c) begin
            dcnt <= '0;
         end else if (sample_valid) begin
            dcnt <= (dcnt == decim) ? '0 : dcnt + DECIM_WIDTH'(1);
         end
      end
   end

   // State register and registered outputs
   always_ff @(posedge CLK104MHZ) begin
      if (reset) begin
         state       <= S_ARM;
         tcnt        <= '0;
         prev        <= '0;
         prev_valid  <= 1'b0;
         ADD_W       <= '0;
         DIN         <= '0;
         WE0         <= 1'b0;
         WE1         <= 1'b0;
         frame_ready <= 1'b0;
         auto_trig   <= 1'b0;
         torn_count  <= '0;
      end else begin
         state       <= state_n;
         tcnt        <= tcnt_n;
         prev        <= prev_n;
         prev_valid  <= prev_valid_n;
         ADD_W       <= add_w_n;
         DIN         <= din_n;
         WE0         <= we0_n;
         WE1         <= we1_n;
         frame_ready <= frame_ready_n;
         auto_trig   <= auto_trig_n;
         torn_count  <= torn_count_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n      = state;
      tcnt_n       = tcnt;
      prev_n       = prev;
      prev_valid_n = prev_valid;
      add_w_n      = ADD_W;
      din_n        = DIN;
      auto_trig_n  = auto_trig;
      torn_count_n = torn_count;
      write_c      = 1'b0;
      start_c      = 1'b0;

      case (state)
         S_ARM: begin
            if (swap_c) begin
               tcnt_n       = '0;
               prev_valid_n = 1'b0;
            end else if (accept_c) begin
               if (!trig_en) begin
                  start_c     = 1'b1;
                  auto_trig_n = 1'b0;
               end else if (rise_c) begin
                  start_c     = 1'b1;
                  auto_trig_n = 1'b0;
               end else if (tcnt == TIMEOUT_LAST) begin
                  start_c     = 1'b1;
                  auto_trig_n = 1'b1;
               end else begin
                  prev_n       = cur_c;
                  prev_valid_n = 1'b1;
                  tcnt_n       = tcnt + TIMEOUT_WIDTH'(1);
               end
               if (start_c) begin
                  write_c      = 1'b1;
                  add_w_n      = '0;
                  din_n        = sample_in;
                  tcnt_n       = '0;
                  prev_valid_n = 1'b0;
                  state_n      = (LAST_ADDR == '0) ? S_DONE : S_FILL;
               end
            end
         end
         S_FILL: begin
            if (swap_c) begin
               state_n = S_ARM;
               if (torn_count != 8'hFF) begin
                  torn_count_n = torn_count + 8'd1;
               end
            end else if (accept_c) begin
               write_c = 1'b1;
               add_w_n = addr_inc_c;
               din_n   = sample_in;
               if (addr_inc_c == LAST_ADDR) begin
                  state_n = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (swap_c) begin
               state_n = S_ARM;
            end
         end
         default: begin
            state_n = S_ARM;
         end
      endcase

      // Writes never occur on a swap, so the live select names the write bank
      we0_n         = write_c & activeBRAMselect;
      we1_n         = write_c & ~activeBRAMselect;
      frame_ready_n = (state_n == S_DONE);
   end

endmodule

// File: tb/tb_sample_buffer_writer.sv
// Directed bench for sample_buffer_writer: free-run fill, bank swap, level
// trigger, timeout auto-trigger, decimation, torn fill and mid-fill reset.
module tb_sample_buffer_writer;

   logic        clk;
   logic        reset;
   logic [11:0] sample_in;
   logic        sample_valid;
   logic [7:0]  decim;
   logic        trig_en;
   logic        active_sel;
   logic [10:0] add_w;
   logic [11:0] din;
   logic        we0;
   logic        we1;
   logic        frame_ready;
   logic        auto_trig;
   logic [7:0]  torn_count;

   int checks = 0;
   int errors = 0;

   sample_buffer_writer #(
      .TRIG_TIMEOUT(16)
   ) dut (
      .CLK104MHZ       (clk),
      .reset           (reset),
      .sample_in       (sample_in),
      .sample_valid    (sample_valid),
      .decim           (decim),
      .trig_en         (trig_en),
      .activeBRAMselect(active_sel),
      .ADD_W           (add_w),
      .DIN             (din),
      .WE0             (we0),
      .WE1             (we1),
      .frame_ready     (frame_ready),
      .auto_trig       (auto_trig),
      .torn_count      (torn_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one valid sample for one cycle and advance past the edge
   task automatic push(input logic [11:0] v);
      sample_valid = 1'b1;
      sample_in    = v;
      step();
      sample_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic check_write(input string tag, input logic exp_we0, input logic exp_we1,
                              input int exp_addr, input int exp_din);
      check({tag, "_we0"}, 32'(we0), 32'(exp_we0));
      check({tag, "_we1"}, 32'(we1), 32'(exp_we1));
      check({tag, "_addr"}, 32'(add_w), 32'(exp_addr));
      check({tag, "_din"}, 32'(din), 32'(exp_din));
   endtask

   initial begin
      reset        = 1'b1;
      sample_in    = '0;
      sample_valid = 1'b0;
      decim        = 8'd0;
      trig_en      = 1'b0;
      active_sel   = 1'b0;
      do_reset();

      // Reset values
      check("rst_addr", 32'(add_w), 0);
      check("rst_din", 32'(din), 0);
      check("rst_we0", 32'(we0), 0);
      check("rst_we1", 32'(we1), 0);
      check("rst_frame_ready", 32'(frame_ready), 0);
      check("rst_auto_trig", 32'(auto_trig), 0);
      check("rst_torn", 32'(torn_count), 0);

      // Free-run fill of bank 1 with back-to-back samples 0..1279
      sample_valid = 1'b1;
      for (int k = 0; k < 1280; k++) begin
         sample_in = 12'(k);
         step();
         check_write("free", 1'b0, 1'b1, k, k);
         check("free_frame_ready", 32'(frame_ready), 32'(k == 1279));
      end
      sample_in = 12'd5;
      for (int k = 0; k < 4; k++) begin
         step();
         check("done_we0", 32'(we0), 0);
         check("done_we1", 32'(we1), 0);
         check("done_frame_ready", 32'(frame_ready), 1);
         check("done_addr_hold", 32'(add_w), 1279);
      end
      sample_valid = 1'b0;

      // Swap from DONE: frame_ready drops, next accept writes bank 0 at 0
      active_sel = 1'b1;
      step();
      check("swap_frame_ready", 32'(frame_ready), 0);
      check("swap_we0", 32'(we0), 0);
      check("swap_we1", 32'(we1), 0);
      push(12'd42);
      check_write("after_swap", 1'b1, 1'b0, 0, 42);
      check("after_swap_torn", 32'(torn_count), 0);
      push(12'd43);
      push(12'd44);
      check_write("after_swap2", 1'b1, 1'b0, 2, 44);

      // Reset mid-fill with a valid sample present
      sample_valid = 1'b1;
      sample_in    = 12'd99;
      reset        = 1'b1;
      step();
      reset        = 1'b0;
      sample_valid = 1'b0;
      check_write("midrst", 1'b0, 1'b0, 0, 0);
      check("midrst_frame_ready", 32'(frame_ready), 0);
      check("midrst_auto_trig", 32'(auto_trig), 0);
      check("midrst_torn", 32'(torn_count), 0);

      // Level trigger: -5 primes, -1 no crossing, 0 triggers, 3 follows
      trig_en = 1'b1;
      push(12'hFFB);
      check("trig_m5_we0", 32'(we0), 0);
      push(12'hFFF);
      check("trig_m1_we0", 32'(we0), 0);
      push(12'd0);
      check_write("trig_first", 1'b1, 1'b0, 0, 0);
      check("trig_auto", 32'(auto_trig), 0);
      push(12'd3);
      check_write("trig_second", 1'b1, 1'b0, 1, 3);

      // Continue fill up to address 500, then swap mid-fill
      sample_valid = 1'b1;
      for (int k = 2; k <= 500; k++) begin
         sample_in = 12'(k);
         step();
      end
      check_write("fill500", 1'b1, 1'b0, 500, 500);
      active_sel = 1'b0;
      sample_in  = 12'd600;
      step();
      check("torn_we0", 32'(we0), 0);
      check("torn_we1", 32'(we1), 0);
      check("torn_count", 32'(torn_count), 1);
      check("torn_frame_ready", 32'(frame_ready), 0);
      sample_valid = 1'b0;
      trig_en      = 1'b0;
      push(12'd77);
      check_write("refill", 1'b0, 1'b1, 0, 77);
      check("refill_torn", 32'(torn_count), 1);

      // Timeout auto-trigger: constant -100, 16th accepted sample starts
      do_reset();
      trig_en = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         push(12'hF9C);
         if (k < 16) begin
            check("tmo_wait_we1", 32'(we1), 0);
         end
      end
      check_write("tmo_first", 1'b0, 1'b1, 0, 3996);
      check("tmo_auto", 32'(auto_trig), 1);
      push(12'hF9C);
      check_write("tmo_second", 1'b0, 1'b1, 1, 3996);
      check("tmo_auto_hold", 32'(auto_trig), 1);

      // Decimation by 4: samples 3,7,11,15 land at addresses 0..3
      do_reset();
      trig_en = 1'b0;
      decim   = 8'd3;
      sample_valid = 1'b1;
      for (int k = 0; k < 16; k++) begin
         sample_in = 12'(k);
         step();
         if ((k % 4) == 3) begin
            check_write("decim", 1'b0, 1'b1, k / 4, k);
         end else begin
            check("decim_skip_we1", 32'(we1), 0);
         end
      end
      sample_valid = 1'b0;
      check("decim_auto", 32'(auto_trig), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sample_buffer_writer.md
# sample_buffer_writer

Write side of the ping-pong sample buffer feeding the VGA signal drawer. Accepts signed ADC samples from the XADC controller, decimates them, and arms on a rising-edge level trigger with an auto-trigger timeout. It then writes one frame of DEPTH samples into whichever BRAM the drawer is not reading. It follows the drawer's `activeBRAMselect` toggle to swap banks, so the drawer always displays a complete, trigger-aligned trace.

## Interface
- `SAMPLE_WIDTH`, 12, sample width (two's complement)
- `ADD_SIZE`, 11, BRAM address width
- `DEPTH`, 1280, samples per frame (= active horizontal pixels)
- `DECIM_WIDTH`, 8, width of decimation control
- `TRIG_LEVEL`, 0, signed trigger threshold
- `TIMEOUT_WIDTH`, 12, width of trigger-timeout counter
- `TRIG_TIMEOUT`, 4095, accepted samples in ARM before auto-trigger (≥1)

Ports:
- `CLK104MHZ` in 1 — single clock, all logic on rising edge
- `reset` in 1 — synchronous, active-high
- `sample_in` in SAMPLE_WIDTH — signed ADC sample
- `sample_valid` in 1 — one-cycle strobe; `sample_in` is valid this cycle
- `decim` in DECIM_WIDTH — keep one of every `decim`+1 valid samples
- `trig_en` in 1 — 1: wait for trigger; 0: free-run
- `activeBRAMselect` in 1 — bank the drawer is reading
- `ADD_W` out ADD_SIZE — write address
- `DIN` out SAMPLE_WIDTH — write data
- `WE0` out 1 — write enable, BRAM 0
- `WE1` out 1 — write enable, BRAM 1
- `frame_ready` out 1 — level; the write bank holds a complete frame
- `auto_trig` out 1 — the current/last frame started by timeout
- `torn_count` out 8 — saturating count of fills aborted by a bank swap

## Operation
- Write bank = ~`activeBRAMselect`. The block never writes the bank the drawer is reading.
- Swap detect: `sel_q` registers `activeBRAMselect`. A swap is `activeBRAMselect != sel_q` and acts in the same cycle. `reset` loads `sel_q` from the input, so reset never produces a swap.
- Decimation: counter `dcnt`. On `sample_valid`:
  - if `dcnt == decim`, the sample is accepted and `dcnt` ← 0;
  - else `dcnt`++.
  - `decim` = 0 accepts every valid sample.
  - A swap clears `dcnt`.
- States:
  - ARM:
    - `trig_en`=0: the first accepted sample starts the fill.
    - `trig_en`=1, real trigger: `prev < TRIG_LEVEL && cur >= TRIG_LEVEL` (signed). The first accepted sample after entering ARM only loads `prev`. This starts the fill with `auto_trig`←0.
    - `trig_en`=1, timeout: the `TRIG_TIMEOUT`-th accepted sample in ARM starts the fill with `auto_trig`←1. `auto_trig`←0 when the fill starts in free-run.
    - The starting sample is written at address 0. Go to FILL.
  - FILL:
    - Each accepted sample is written at the next address.
    - After the write to address DEPTH-1, go to DONE.
  - DONE:
    - No writes; `frame_ready`=1.
    - Samples are still consumed by the decimator.
    - A swap leads to ARM.
- Swap in FILL:
  - go to ARM; `torn_count`++ (saturates at 255);
  - the next frame restarts at address 0 in the new write bank.
- Swap in ARM: stay in ARM; clear the timeout counter and the `prev`-valid flag.
- Swap coincident with an accepted sample: the swap wins and the sample is discarded.
- Address and timeout counters are exact-width and never wrap. The address stops at DEPTH-1.

## Timing
- Reset values: state ARM, `ADD_W`=0, `DIN`=0, `WE0`=`WE1`=0, `frame_ready`=0, `auto_trig`=0, `torn_count`=0, `dcnt`=0, timeout=0.
- Accept in cycle N produces a one-cycle `WE0` or `WE1` pulse in cycle N+1, with `ADD_W`/`DIN` registered valid in that cycle. At most one of `WE0`/`WE1` is high, never both.
- `frame_ready` rises in the same cycle as the WE pulse for address DEPTH-1. It falls in the cycle after a swap is detected.
- Swap detected in cycle N: state changes at the N+1 edge. No WE is asserted in N+1.
- `sample_valid` may be high every cycle: full throughput, one write per cycle.
- `reset` mid-FILL: all outputs take reset values on the next edge. The partially written bank is simply left as is.

## Test plan
- Free-run fill: `decim`=0, `trig_en`=0, `activeBRAMselect`=0, 1280 back-to-back samples 0..1279 -> 1280 `WE1` pulses with `ADD_W`=`DIN`=k, `WE0` never; `frame_ready`=1 with the last pulse; further samples produce no WE.
- Bank swap from DONE: toggle `activeBRAMselect` to 1 -> `frame_ready` 0 next cycle; the next accepted sample gives `WE0` at `ADD_W`=0; `torn_count` stays 0.
- Level trigger: `trig_en`=1, `TRIG_LEVEL`=0, samples -5,-1,0,3 -> first WE at `ADD_W`=0 with `DIN`=0, next at 1 with `DIN`=3; `auto_trig`=0.
- Timeout: `TRIG_TIMEOUT`=16, constant -100 -> the 16th accepted sample is written at address 0; `auto_trig`=1.
- Decimation: `decim`=3, valid samples valued 0,1,2,… -> writes `DIN`=3,7,11,… at addresses 0,1,2,….
- Mid-fill events:
  - toggle `activeBRAMselect` after address 500 is written -> no WE the next cycle, `torn_count`=1, refill from address 0 in the other bank;
  - assert `reset` mid-fill -> all outputs at reset values one edge later.
